// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: state type, requester index type and requester IDs for mem_bus_arbiter
package mem_arb_pkg;
   localparam int NUM_REQ_DEF = 3;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} arb_state_e;
   typedef logic [$clog2(NUM_REQ_DEF)-1:0] req_idx_t;
   localparam req_idx_t REQ_IBEX_I = req_idx_t'(0);
   localparam req_idx_t REQ_IBEX_D = req_idx_t'(1);
   localparam req_idx_t REQ_VPROC  = req_idx_t'(2);
endpackage

// File: rtl/mem_arb_rr_pick.sv
// mem_arb_rr_pick: round-robin winner search starting just after i_ptr
module mem_arb_rr_pick #(
   parameter int NUM_REQ = 3
) (
   input  logic [NUM_REQ-1:0]         i_req,
   input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
   output logic                       o_valid,
   output logic [$clog2(NUM_REQ)-1:0] o_idx
);
   localparam int IW = $clog2(NUM_REQ);
   // scan farthest-first so the nearest requester after i_ptr is written last
   always_comb begin
      o_valid = 1'b0;
      o_idx = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         logic [IW-1:0] c;
         c = IW'((int'(i_ptr) + k) % NUM_REQ);
         if (i_req[c]) begin
            o_valid = 1'b1;
            o_idx = c;
         end
      end
   end
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin sharing of one MMU port, one transaction in flight.
// MEM_ARB_TIMEOUT_EN adds a WAIT watchdog that errors the owner after TIMEOUT_CYCLES.
module mem_bus_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int MEM_W = 32
`ifdef MEM_ARB_TIMEOUT_EN
   , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_REQ-1:0]              up_req_i,
   input  logic [NUM_REQ-1:0][31:0]        up_addr_i,
   input  logic [NUM_REQ-1:0]              up_we_i,
   input  logic [NUM_REQ-1:0][MEM_W/8-1:0] up_be_i,
   input  logic [NUM_REQ-1:0][MEM_W-1:0]   up_wdata_i,
   output logic [NUM_REQ-1:0]              up_gnt_o,
   output logic [NUM_REQ-1:0]              up_rvalid_o,
   output logic [NUM_REQ-1:0]              up_err_o,
   output logic [MEM_W-1:0]                up_rdata_o,
   output logic                            dn_req_o,
   output logic [31:0]                     dn_addr_o,
   output logic                            dn_we_o,
   output logic [MEM_W/8-1:0]              dn_be_o,
   output logic [MEM_W-1:0]                dn_wdata_o,
   input  logic                            dn_rvalid_i,
   input  logic                            dn_err_i,
   input  logic [MEM_W-1:0]                dn_rdata_i,
   output logic                            spurious_rsp_o
);
   localparam int IW = $clog2(NUM_REQ);
   arb_state_e          r_state, w_next;
   logic [IW-1:0]       r_ptr, w_win;
   logic                w_valid, w_rsp, w_to, w_wait;
   logic [NUM_REQ-1:0]  w_own;
   logic [31:0]         r_addr;
   logic                r_we, r_spur;
   logic [MEM_W/8-1:0]  r_be;
   logic [MEM_W-1:0]    r_wdata;

   mem_arb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .i_req(up_req_i), .i_ptr(r_ptr), .o_valid(w_valid), .o_idx(w_win)
   );

   // r_ptr doubles as the owner: it is loaded with the winner at capture
   assign w_own = NUM_REQ'(1) << r_ptr;
   assign w_rsp = dn_rvalid_i | dn_err_i;
   assign w_wait = r_state == WAIT;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] r_cnt;
   always_ff @(posedge clk) r_cnt <= (!rst || !w_wait) ? '0 : r_cnt + CW'(1);
   assign w_to = w_wait && r_cnt == CW'(TIMEOUT_CYCLES) && !w_rsp;
`else
   assign w_to = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= IDLE;
         r_ptr <= IW'(NUM_REQ - 1);
         r_addr <= '0;
         r_we <= 1'b0;
         r_be <= '0;
         r_wdata <= '0;
         r_spur <= 1'b0;
      end else begin
         r_state <= w_next;
         if (!w_wait && w_rsp) r_spur <= 1'b1;
         if (r_state == IDLE && w_valid) begin
            r_ptr <= w_win;
            r_addr <= up_addr_i[w_win];
            r_we <= up_we_i[w_win];
            r_be <= up_be_i[w_win];
            r_wdata <= up_wdata_i[w_win];
         end
      end
   end

   always_comb begin
      w_next = (r_state == IDLE) ? (w_valid ? ISSUE : IDLE) :
               (r_state == ISSUE) ? WAIT : ((w_rsp || w_to) ? IDLE : WAIT);
      up_gnt_o = (r_state == ISSUE) ? w_own : '0;
      up_rvalid_o = (w_wait && dn_rvalid_i && !dn_err_i) ? w_own : '0;
      up_err_o = (w_wait && (dn_err_i || w_to)) ? w_own : '0;
      up_rdata_o = (w_wait && dn_rvalid_i && !dn_err_i) ? dn_rdata_i : '0;
   end

   assign dn_req_o = r_state == ISSUE;
   assign dn_addr_o = r_addr;
   assign dn_we_o = r_we;
   assign dn_be_o = r_be;
   assign dn_wdata_o = r_wdata;
   assign spurious_rsp_o = r_spur;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed scenarios plus random traffic against a transaction-level model
module tb_mem_bus_arbiter;
   import mem_arb_pkg::*;
   localparam int N = 3;
   localparam int TO = 16;
`ifdef MEM_ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif
   logic clk = 1'b0, rst = 1'b0;
   logic [N-1:0] up_req_i = '0, up_we_i = '0;
   logic [N-1:0][31:0] up_addr_i = '0, up_wdata_i = '0;
   logic [N-1:0][3:0] up_be_i = '0;
   logic [N-1:0] up_gnt_o, up_rvalid_o, up_err_o;
   logic [31:0] up_rdata_o, dn_addr_o, dn_wdata_o;
   logic [31:0] dn_rdata_i = '0;
   logic dn_req_o, dn_we_o, spurious_rsp_o;
   logic dn_rvalid_i = 1'b0, dn_err_i = 1'b0;
   logic [3:0] dn_be_o;
   int total = 0, bad = 0;

   always #5 clk = ~clk;

   mem_bus_arbiter #(
      .NUM_REQ(N), .MEM_W(32)
`ifdef MEM_ARB_TIMEOUT_EN
      , .TIMEOUT_CYCLES(TO)
`endif
   ) dut (
      .clk(clk), .rst(rst), .up_req_i(up_req_i), .up_addr_i(up_addr_i), .up_we_i(up_we_i),
      .up_be_i(up_be_i), .up_wdata_i(up_wdata_i), .up_gnt_o(up_gnt_o), .up_rvalid_o(up_rvalid_o),
      .up_err_o(up_err_o), .up_rdata_o(up_rdata_o), .dn_req_o(dn_req_o), .dn_addr_o(dn_addr_o),
      .dn_we_o(dn_we_o), .dn_be_o(dn_be_o), .dn_wdata_o(dn_wdata_o), .dn_rvalid_i(dn_rvalid_i),
      .dn_err_i(dn_err_i), .dn_rdata_i(dn_rdata_i), .spurious_rsp_o(spurious_rsp_o)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // transaction-level model: free / granting / waiting, winner = nearest requester after the last owner
   bit m_init = 1'b0, m_busy, m_issue, m_spur, m_we;
   int m_owner, m_last, m_wc;
   logic [31:0] m_addr, m_wd;
   logic [3:0] m_be;

   always @(negedge clk) begin : cmp
      logic [N-1:0] eg, ev, ee;
      bit in_wait, rsp, to_hit;
      int best, bd, d;
      in_wait = m_busy && !m_issue;
      rsp = dn_rvalid_i || dn_err_i;
      to_hit = TO_EN && in_wait && !rsp && m_wc == TO;
      eg = m_issue ? N'(1) << m_owner : '0;
      ev = (in_wait && dn_rvalid_i && !dn_err_i) ? N'(1) << m_owner : '0;
      ee = (in_wait && (dn_err_i || to_hit)) ? N'(1) << m_owner : '0;
      if (m_init) begin
         chk("gnt", up_gnt_o, eg);
         chk("dn_req", dn_req_o, m_issue);
         chk("dn_addr", dn_addr_o, m_addr);
         chk("dn_we", dn_we_o, m_we);
         chk("dn_be", dn_be_o, m_be);
         chk("dn_wdata", dn_wdata_o, m_wd);
         chk("rvalid", up_rvalid_o, ev);
         chk("err", up_err_o, ee);
         chk("rdata", up_rdata_o, ev != 0 ? dn_rdata_i : 32'h0);
         chk("spurious", spurious_rsp_o, m_spur);
      end
      if (!rst) begin
         m_init = 1'b1; m_busy = 1'b0; m_issue = 1'b0; m_last = N - 1; m_spur = 1'b0;
         m_addr = '0; m_we = 1'b0; m_be = '0; m_wd = '0; m_wc = 0; m_owner = 0;
      end else if (m_init) begin
         if (!in_wait && rsp) m_spur = 1'b1;
         if (in_wait) begin
            if (rsp || to_hit) m_busy = 1'b0;
            else m_wc++;
         end else if (m_issue) begin
            m_issue = 1'b0;
            m_wc = 0;
         end else if (up_req_i != 0) begin
            best = 0; bd = N;
            for (int i = 0; i < N; i++) begin
               d = (i - m_last - 1 + 2 * N) % N;
               if (up_req_i[i] && d < bd) begin bd = d; best = i; end
            end
            m_owner = best; m_last = best;
            m_addr = up_addr_i[best]; m_we = up_we_i[best]; m_be = up_be_i[best]; m_wd = up_wdata_i[best];
            m_busy = 1'b1; m_issue = 1'b1;
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_gnt(output int idx, output int lat);
      idx = -1;
      lat = 0;
      for (int n = 1; n <= 10 && idx < 0; n++) begin
         tick;
         if (up_gnt_o != 0) begin
            lat = n;
            for (int i = 0; i < N; i++) if (up_gnt_o[i]) idx = i;
         end
      end
      chk("gnt_seen", idx >= 0, 1);
   endtask

   initial begin
      int idx, lat, k, rc, r;
      repeat (3) tick;
      chk("rst_gnt", up_gnt_o, 0);
      chk("rst_dnreq", dn_req_o, 0);
      chk("rst_spur", spurious_rsp_o, 0);
      chk("rst_addr", dn_addr_o, 0);
      rst = 1'b1;
      // single read from requester 1
      up_req_i[1] = 1'b1; up_addr_i[1] = 32'h1004; up_we_i[1] = 1'b0; up_be_i[1] = 4'hf;
      wait_gnt(idx, lat);
      chk("rd_idx", idx, REQ_IBEX_D);
      chk("rd_lat", lat, 1);
      chk("rd_addr", dn_addr_o, 32'h1004);
      chk("rd_dnreq", dn_req_o, 1);
      up_req_i[1] = 1'b0;
      tick;
      dn_rvalid_i = 1'b1; dn_rdata_i = 32'hDEADBEEF;
      #1;
      chk("rd_rvalid", up_rvalid_o, 3'b010);
      chk("rd_rdata", up_rdata_o, 32'hDEADBEEF);
      chk("rd_hold", dn_addr_o, 32'h1004);
      tick;
      dn_rvalid_i = 1'b0;
      // all held high from reset: 0,1,2,0,1,2
      rst = 1'b0;
      tick;
      rst = 1'b1;
      for (int i = 0; i < N; i++) begin up_req_i[i] = 1'b1; up_addr_i[i] = 32'h100 * i; end
      for (int n = 0; n < 6; n++) begin
         wait_gnt(idx, lat);
         chk("rr_order", idx, n % 3);
         tick;
         dn_rvalid_i = 1'b1; dn_rdata_i = $urandom;
         tick;
         dn_rvalid_i = 1'b0;
      end
      up_req_i = '0;
      // write answered with err and rvalid together
      up_req_i[2] = 1'b1; up_addr_i[2] = 32'h2000; up_we_i[2] = 1'b1; up_wdata_i[2] = 32'h55;
      wait_gnt(idx, lat);
      chk("wr_idx", idx, REQ_VPROC);
      chk("wr_we", dn_we_o, 1);
      up_req_i[2] = 1'b0;
      tick;
      dn_err_i = 1'b1; dn_rvalid_i = 1'b1; dn_rdata_i = 32'h1234;
      #1;
      chk("wr_err", up_err_o, 3'b100);
      chk("wr_rvalid", up_rvalid_o, 0);
      chk("wr_rdata", up_rdata_o, 0);
      tick;
      dn_err_i = 1'b0; dn_rvalid_i = 1'b0;
      // response while idle
      dn_rvalid_i = 1'b1;
      #1;
      chk("spur_norv", up_rvalid_o, 0);
      tick;
      dn_rvalid_i = 1'b0;
      chk("spur_set", spurious_rsp_o, 1);
      repeat (3) tick;
      chk("spur_sticky", spurious_rsp_o, 1);
      rst = 1'b0;
      tick;
      rst = 1'b1;
      chk("spur_clr", spurious_rsp_o, 0);
      // reset while waiting, then a late response
      up_req_i[1] = 1'b1;
      wait_gnt(idx, lat);
      up_req_i[1] = 1'b0;
      tick;
      rst = 1'b0;
      tick;
      rst = 1'b1;
      dn_rvalid_i = 1'b1;
      #1;
      chk("rstw_norv", up_rvalid_o, 0);
      chk("rstw_noerr", up_err_o, 0);
      tick;
      dn_rvalid_i = 1'b0;
      chk("rstw_spur", spurious_rsp_o, 1);
      up_req_i = '1;
      wait_gnt(idx, lat);
      chk("rstw_first", idx, REQ_IBEX_I);
      up_req_i = '0;
      tick;
      dn_rvalid_i = 1'b1;
      tick;
      dn_rvalid_i = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      up_req_i[0] = 1'b1;
      wait_gnt(idx, lat);
      up_req_i[0] = 1'b0;
      tick;
      k = 0;
      while (up_err_o == 0 && k < 40) begin tick; k++; end
      chk("to_cycles", k, TO);
      chk("to_err", up_err_o, 3'b001);
      tick;
      dn_rvalid_i = 1'b1;
      tick;
      dn_rvalid_i = 1'b0;
      chk("to_late_spur", spurious_rsp_o, 1);
      rst = 1'b0;
      tick;
      rst = 1'b1;
`endif
      // random traffic
      rc = 0;
      repeat (3000) begin
         tick;
         dn_rvalid_i = 1'b0; dn_err_i = 1'b0;
         if (rc > 0) begin
            rc--;
            if (rc == 0) begin
               r = $urandom % 100;
               dn_rvalid_i = r < 85; dn_err_i = r >= 70; dn_rdata_i = $urandom;
            end
         end
         if (dn_req_o) rc = 1 + $urandom % 3;
         for (int i = 0; i < N; i++) begin
            if (up_req_i[i]) begin
               if (up_gnt_o[i] && $urandom % 2 == 0) up_req_i[i] = 1'b0;
            end else if ($urandom % 4 == 0) begin
               up_req_i[i] = 1'b1; up_addr_i[i] = $urandom; up_we_i[i] = $urandom % 2;
               up_be_i[i] = 4'($urandom); up_wdata_i[i] = $urandom;
            end
         end
      end
      up_req_i = '0;
      repeat (8) tick;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
